// File: rtl/rect_fill_pkg.sv
// Shared definitions for the rectangle fill engine.
// Holds the FSM encoding and framebuffer geometry.
package rect_fill_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int ADDR_W   = 17;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/raster_step.sv
// Column/row walker for a clipped rectangle.
// Produces the next linear address without any multiply.
module raster_step
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = rect_fill_pkg::SCREEN_W,
    parameter int ADDR_W   = rect_fill_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init,
    input  logic              advance,
    input  logic [9:0]        cw_in,
    input  logic [8:0]        ch_in,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [8:0]        x0,
    output logic              last,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_W);

    logic [9:0]        col;
    logic [9:0]        cw;
    logic [8:0]        row;
    logic [8:0]        ch;
    logic [ADDR_W-1:0] row_base;
    logic              row_end;

    assign row_end = (col == cw - 10'd1);
    assign last    = row_end && (row == ch - 9'd1);

    // Address of the pixel after the current one, wrapping to the next row.
    always_comb begin
        next_addr = row_base + ADDR_W'(x0) + ADDR_W'(col) + ADDR_W'(1);
        if (row_end) begin
            next_addr = row_base + ROW_STEP + ADDR_W'(x0);
        end
    end

    // Counters load on init and step on each completed write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col      <= '0;
            row      <= '0;
            cw       <= '0;
            ch       <= '0;
            row_base <= '0;
        end else if (init) begin
            col      <= '0;
            row      <= '0;
            cw       <= cw_in;
            ch       <= ch_in;
            row_base <= base_in;
        end else if (advance) begin
            if (row_end) begin
                col      <= '0;
                row      <= row + 9'd1;
                row_base <= row_base + ROW_STEP;
            end else begin
                col <= col + 10'd1;
            end
        end
    end

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: clips a box to the screen
// and streams one framebuffer write per accepted cycle.
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = rect_fill_pkg::SCREEN_W,
    parameter int SCREEN_H = rect_fill_pkg::SCREEN_H,
    parameter int ADDR_W   = rect_fill_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [8:0]        x0,
    input  logic [7:0]        y0,
    input  logic [8:0]        w,
    input  logic [7:0]        h,
    input  logic [2:0]        colour,
    input  logic              mem_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_colour,
    output logic              busy,
    output logic              done
);

    localparam logic [9:0] SW10 = 10'(SCREEN_W);
    localparam logic [8:0] SH9  = 9'(SCREEN_H);

    state_t            state;
    state_t            state_n;
    logic [8:0]        x0_q;
    logic [7:0]        y0_q;
    logic [8:0]        w_q;
    logic [7:0]        h_q;
    logic [9:0]        cw;
    logic [8:0]        ch;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] next_addr;
    logic              last;
    logic              advance;

    assign advance   = (state == S_RUN) && mem_ready;
    assign wr_en     = (state == S_RUN);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign base      = ADDR_W'(y0_q) * ADDR_W'(SCREEN_W);

    // Clip the latched box against the screen edges.
    always_comb begin
        cw = '0;
        ch = '0;
        if ({1'b0, x0_q} < SW10) begin
            cw = SW10 - {1'b0, x0_q};
            if ({1'b0, w_q} < cw) cw = {1'b0, w_q};
        end
        if ({1'b0, y0_q} < SH9) begin
            ch = SH9 - {1'b0, y0_q};
            if ({1'b0, h_q} < ch) ch = {1'b0, h_q};
        end
    end

    raster_step #(
        .SCREEN_W (SCREEN_W),
        .ADDR_W   (ADDR_W)
    ) u_step (
        .clk       (clk),
        .resetn    (resetn),
        .init      (state == S_SETUP),
        .advance   (advance),
        .cw_in     (cw),
        .ch_in     (ch),
        .base_in   (base),
        .x0        (x0_q),
        .last      (last),
        .next_addr (next_addr)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = S_SETUP;
            S_SETUP: state_n = (cw == 10'd0 || ch == 9'd0) ? S_DONE : S_RUN;
            S_RUN:   if (advance && last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Command latch and registered write address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            wr_colour <= '0;
            wr_addr   <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                x0_q      <= x0;
                y0_q      <= y0;
                w_q       <= w;
                h_q       <= h;
                wr_colour <= colour;
            end
            if (state == S_SETUP) wr_addr <= base + ADDR_W'(x0_q);
            else if (advance)     wr_addr <= next_addr;
        end
    end

endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Parameters
REQ-001 SCREEN_W, 320, framebuffer width in pixels.
REQ-002 SCREEN_H, 240, framebuffer height in pixels.
REQ-003 ADDR_W, 17, framebuffer address width; SCREEN_W*SCREEN_H SHALL fit in ADDR_W bits.

Interface
REQ-004 clk  in  1  single clock; all state SHALL change on posedge clk.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request pulse; sampled only in IDLE.
REQ-007 x0  in  9  left column, unsigned.
REQ-008 y0  in  8  top row, unsigned.
REQ-009 w  in  9  width in pixels.
REQ-010 h  in  8  height in pixels.
REQ-011 colour  in  3  fill colour.
REQ-012 mem_ready  in  1  framebuffer accepts the write this cycle.
REQ-013 wr_en  out  1  write request valid.
REQ-014 wr_addr  out  ADDR_W  linear address y*SCREEN_W + x.
REQ-015 wr_colour  out  3  latched colour.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse on completion.

Function
REQ-018 States: IDLE, SETUP, RUN, DONE; encoding SHALL be defined in the shared package.
REQ-019 IDLE: start=1 SHALL latch x0, y0, w, h and colour, then go to SETUP; start=0 stays in IDLE.
REQ-020 SETUP: one cycle; computes clipped width cw=min(w, SCREEN_W-x0) and clipped height ch=min(h, SCREEN_H-y0), with 0 if x0>=SCREEN_W or y0>=SCREEN_H; computes row_base=y0*SCREEN_W and resets the column and row counters.
REQ-021 SETUP with cw=0 or ch=0 SHALL go to DONE with no write; otherwise it goes to RUN.
REQ-022 RUN: wr_en=1 every cycle; wr_addr=row_base+x0+col, col in 0..cw-1; registered output.
REQ-023 A write completes only on a cycle with wr_en=1 and mem_ready=1; on mem_ready=0, wr_addr and wr_colour SHALL hold.
REQ-024 Completed write with col=cw-1 SHALL set col=0, increment row, and add SCREEN_W to row_base; otherwise col increments.
REQ-025 Completed write with col=cw-1 and row=ch-1 SHALL go to DONE; wr_en SHALL be low on the next cycle.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 Exactly cw*ch writes SHALL complete per command, in raster order; no address repeats or is skipped.
REQ-028 Latency: with mem_ready held high, the first wr_en is 2 cycles after start and done is cw*ch+2 cycles after start.
REQ-029 start while busy SHALL be ignored and not queued.
REQ-030 Arithmetic SHALL be unsigned with widths large enough that no intermediate overflows for any input value.

Reset
REQ-031 resetn=0 at any time, including mid-RUN, SHALL force IDLE asynchronously.
REQ-032 During reset, wr_en=0, busy=0, done=0, wr_addr=0 and wr_colour=0; the aborted fill is not resumed.
REQ-033 The first start is accepted on the first posedge after resetn rises.

Structure
REQ-034 Shared package: state encoding, SCREEN_W, SCREEN_H and ADDR_W (the framebuffer address-width constant).
REQ-035 One sub-module, raster_step, SHALL hold the col/row counters and row_base accumulator, with an advance input and a last-pixel output; rect_fill holds the FSM and I/O registers.
REQ-036 No multiplier in RUN; the only multiply is y0*SCREEN_W in SETUP.

Verification
REQ-037 x0=10, y0=5, w=2, h=2, mem_ready=1 -> addresses 1610, 1611, 1930, 1931 on consecutive cycles; done 6 cycles after start.
REQ-038 Same command with mem_ready toggling 1,0,1,0 -> same 4 addresses in order, each held while stalled; exactly 4 writes complete.
REQ-039 x0=318, y0=0, w=5, h=2 -> clipped to 2 columns: addresses 318, 319, 638, 639.
REQ-040 w=0 and h=3 -> no wr_en; done 2 cycles after start; busy high for exactly 2 cycles.
REQ-041 start repeated 3 cycles into a 4x4 fill -> ignored: 16 writes and one done.
REQ-042 resetn pulsed low after the 5th write of an 8x8 fill -> outputs 0 at once, IDLE; a new 1x1 fill at (0,0) then writes address 0.
